// File: rtl/mux_scan_seq_pkg.sv
// Shared types and constants for the 16:1 mux scan sequencer.
package mux_scan_pkg;

  localparam int NUM_CH     = 16;
  localparam int SEL_W      = 4;
  localparam int SETTLE_MAX = 15;
  localparam int CNT_W      = $clog2(SETTLE_MAX + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_OUT  = 2'd2
  } state_e;

endpackage

// File: rtl/mux_scan_seq_if.sv
// Control, mux and snapshot signals of the scan sequencer.
// master = sequencer side, slave = controller/mux/consumer side.
interface mux_scan_seq_if;
  import mux_scan_pkg::*;

  logic              start;
  logic              abort;
  logic              mode;
  logic [NUM_CH-1:0] ch_mask;
  logic [SEL_W-1:0]  sel;
  logic              q_in;
  logic              busy;
  logic [NUM_CH-1:0] data_out;
  logic              data_valid;
  logic              data_ready;
  logic              overrun;

  modport master (
    input  start, abort, mode, ch_mask, q_in, data_ready,
    output sel, busy, data_out, data_valid, overrun
  );

  modport slave (
    output start, abort, mode, ch_mask, q_in, data_ready,
    input  sel, busy, data_out, data_valid, overrun
  );

endinterface

// File: rtl/mux_scan_seq_next_ch.sv
// Lowest enabled channel strictly above cur_i (or anywhere when incl_i); combinational.
module scan_next_ch
  import mux_scan_pkg::*;
(
  input  logic [NUM_CH-1:0] mask_i,
  input  logic [SEL_W-1:0]  cur_i,
  input  logic              incl_i,
  output logic              found_o,
  output logic [SEL_W-1:0]  ch_o
);

  // Descending walk so the lowest qualifying channel is the last assignment.
  always_comb begin
    found_o = 1'b0;
    ch_o    = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (mask_i[k] && (incl_i || (k > int'(cur_i)))) begin
        found_o = 1'b1;
        ch_o    = SEL_W'(k);
      end
    end
  end

endmodule

// File: rtl/mux_scan_seq.sv
// Sweeps enabled mux channels, dwelling SETTLE+1 cycles each; snapshot after N_en*(SETTLE+1) edges.
// Snapshot held until data_ready; continuous mode stalls (and flags overrun) rather than overwrite.
module mux_scan_seq #(
  parameter int SETTLE = 1,
  parameter int NUM_CH = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  mux_scan_seq_if.master bus
);
  import mux_scan_pkg::*;

  localparam int SETTLE_CL = (SETTLE > SETTLE_MAX) ? SETTLE_MAX : SETTLE;
  localparam logic [CNT_W-1:0] SETTLE_C = CNT_W'(SETTLE_CL);

  state_e            state_q, state_d;
  logic              mode_q, mode_d;
  logic [NUM_CH-1:0] mask_q, mask_d;
  logic [NUM_CH-1:0] word_q, word_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [NUM_CH-1:0] data_q, data_d;
  logic              vld_q, vld_d;
  logic              ovr_q, ovr_d;

  logic [NUM_CH-1:0] first_mask;
  logic              first_found, nxt_found;
  logic [SEL_W-1:0]  first_ch, nxt_ch;
  logic [NUM_CH-1:0] word_cap;

  // IDLE searches the live mask being latched; restarts use the latched copy.
  assign first_mask = (state_q == ST_IDLE) ? bus.ch_mask : mask_q;

  scan_next_ch u_first (
    .mask_i  (first_mask),
    .cur_i   ('0),
    .incl_i  (1'b1),
    .found_o (first_found),
    .ch_o    (first_ch)
  );

  scan_next_ch u_next (
    .mask_i  (mask_q),
    .cur_i   (sel_q),
    .incl_i  (1'b0),
    .found_o (nxt_found),
    .ch_o    (nxt_ch)
  );

  assign word_cap = bus.q_in ? (word_q | (NUM_CH'(1) << sel_q)) : word_q;

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    mask_d  = mask_q;
    word_d  = word_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    data_d  = data_q;
    vld_d   = vld_q;
    ovr_d   = ovr_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          mode_d = bus.mode;
          mask_d = bus.ch_mask;
          word_d = '0;
          ovr_d  = 1'b0;
          cnt_d  = '0;
          if (first_found) begin
            sel_d   = first_ch;
            state_d = ST_SCAN;
          end else begin
            data_d  = '0;
            vld_d   = 1'b1;
            state_d = ST_OUT;
          end
        end
      end

      ST_SCAN: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == SETTLE_C) begin
          word_d = word_cap;
          cnt_d  = '0;
          if (nxt_found) begin
            sel_d = nxt_ch;
          end else begin
            data_d  = word_cap;
            vld_d   = 1'b1;
            state_d = ST_OUT;
          end
        end
      end

      ST_OUT: begin
        if (bus.data_ready) begin
          vld_d = 1'b0;
          if (mode_q) begin
            word_d = '0;
            cnt_d  = '0;
            if (first_found) begin
              sel_d   = first_ch;
              state_d = ST_SCAN;
            end else begin
              data_d = '0;
              vld_d  = 1'b1;
            end
          end else begin
            state_d = ST_IDLE;
          end
        end else if (mode_q) begin
          ovr_d = 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Abort wins over acceptance and sampling; snapshot and select are left as they were.
    if (bus.abort && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      vld_d   = 1'b0;
      data_d  = data_q;
      sel_d   = sel_q;
      word_d  = word_q;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      mode_q  <= 1'b0;
      mask_q  <= '0;
      word_q  <= '0;
      cnt_q   <= '0;
      sel_q   <= '0;
      data_q  <= '0;
      vld_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      mask_q  <= mask_d;
      word_q  <= word_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
      vld_q   <= vld_d;
      ovr_q   <= ovr_d;
    end
  end

  assign bus.sel        = sel_q;
  assign bus.busy       = (state_q != ST_IDLE);
  assign bus.data_out   = data_q;
  assign bus.data_valid = vld_q;
  assign bus.overrun    = ovr_q;

endmodule

// File: tb/tb_mux_scan_seq.sv
// Directed bench for mux_scan_seq (SETTLE=1): vector table of single sweeps plus hand sequences.
module tb_mux_scan_seq;

  logic        clk;
  logic        rst_n;
  logic [15:0] pat;
  int          n_chk;
  int          n_err;

  mux_scan_seq_if bus ();

  mux_scan_seq #(.SETTLE(1), .NUM_CH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  assign bus.q_in = pat[bus.sel];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] mask;
    logic [15:0] pattern;
    logic [15:0] exp_data;
    int          exp_lat;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single-mode sweep from IDLE; optional mid-sweep disturbance of start/mode/ch_mask.
  task automatic run_sweep(input logic [15:0] m, input logic [15:0] p, input logic [15:0] exp_d,
                           input int exp_lat, input bit disturb, input string nm);
    int          lat;
    int          idx;
    int          en[$];
    bit          vis_ok;
    logic [3:0]  sel0;
    for (int k = 0; k < 16; k++) if (m[k]) en.push_back(k);
    sel0         = bus.sel;
    bus.ch_mask  = m;
    pat          = p;
    bus.mode     = 1'b0;
    bus.start    = 1'b1;
    lat          = 0;
    vis_ok       = 1'b1;
    while (lat < 200 && !bus.data_valid) begin
      tick();
      lat++;
      bus.start = 1'b0;
      if (disturb && lat == 5) begin
        bus.ch_mask = 16'h0001;
        bus.start   = 1'b1;
        bus.mode    = 1'b1;
      end
      if (disturb && lat == 6) bus.mode = 1'b0;
      if (!bus.data_valid && en.size() > 0) begin
        idx = (lat - 1) / 2;
        if (idx >= en.size()) vis_ok = 1'b0;
        else if (int'(bus.sel) != en[idx]) vis_ok = 1'b0;
      end
    end
    bus.ch_mask = m;
    chk({nm, " latency"}, lat, exp_lat);
    chk({nm, " data_out"}, bus.data_out, exp_d);
    chk({nm, " busy in OUT"}, bus.busy, 1);
    if (en.size() > 0) chk({nm, " sel visit order"}, vis_ok, 1);
    else chk({nm, " sel unchanged"}, bus.sel, sel0);
    bus.data_ready = 1'b1;
    tick();
    bus.data_ready = 1'b0;
    chk({nm, " valid cleared"}, bus.data_valid, 0);
    chk({nm, " back to idle"}, bus.busy, 0);
  endtask

  initial begin
    int          w;
    bit          vld_seen;
    logic [15:0] held;

    n_chk = 0;
    n_err = 0;
    vecs[0] = '{16'hFFFF, 16'hA5C3, 16'hA5C3, 33};
    vecs[1] = '{16'h8101, 16'hA5C3, 16'h8101, 7};
    vecs[2] = '{16'h0000, 16'hA5C3, 16'h0000, 1};
    vecs[3] = '{16'h0F0F, 16'h1234, 16'h0204, 17};
    vecs[4] = '{16'h8000, 16'hFFFF, 16'h8000, 3};
    vecs[5] = '{16'h0001, 16'h0000, 16'h0000, 3};
    vecs[6] = '{16'h5555, 16'hFFFF, 16'h5555, 17};

    rst_n          = 1'b1;
    pat            = 16'h0000;
    bus.start      = 1'b0;
    bus.abort      = 1'b0;
    bus.mode       = 1'b0;
    bus.ch_mask    = 16'h0000;
    bus.data_ready = 1'b0;
    #3 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset sel", bus.sel, 0);
    chk("reset busy", bus.busy, 0);
    chk("reset data_out", bus.data_out, 0);
    chk("reset data_valid", bus.data_valid, 0);
    chk("reset overrun", bus.overrun, 0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 7; i++)
      run_sweep(vecs[i].mask, vecs[i].pattern, vecs[i].exp_data, vecs[i].exp_lat, 1'b0,
                $sformatf("vec%0d", i));

    // Continuous mode with 10 cycles of backpressure.
    bus.ch_mask = 16'h000F;
    pat         = 16'hA5C3;
    bus.mode    = 1'b1;
    bus.start   = 1'b1;
    w = 0;
    while (w < 100 && !bus.data_valid) begin
      tick();
      w++;
      bus.start = 1'b0;
    end
    chk("cont first latency", w, 9);
    chk("cont first data", bus.data_out, 16'h0003);
    chk("cont overrun before stall", bus.overrun, 0);
    repeat (10) tick();
    chk("cont data stable", bus.data_out, 16'h0003);
    chk("cont valid held", bus.data_valid, 1);
    chk("cont overrun set", bus.overrun, 1);
    chk("cont sel frozen", bus.sel, 3);
    bus.data_ready = 1'b1;
    tick();
    bus.data_ready = 1'b0;
    pat = 16'h000C;
    chk("cont accept clears valid", bus.data_valid, 0);
    chk("cont restart sel", bus.sel, 0);
    chk("cont still busy", bus.busy, 1);
    w = 0;
    while (w < 100 && !bus.data_valid) begin
      tick();
      w++;
    end
    chk("cont second latency", w, 8);
    chk("cont second data", bus.data_out, 16'h000C);
    chk("cont overrun sticky", bus.overrun, 1);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("abort in OUT busy", bus.busy, 0);
    chk("abort in OUT valid", bus.data_valid, 0);
    chk("abort in OUT data kept", bus.data_out, 16'h000C);
    run_sweep(16'h0000, 16'h0000, 16'h0000, 1, 1'b0, "empty after cont");
    chk("start clears overrun", bus.overrun, 0);

    // Abort while scanning channel 5.
    held        = bus.data_out;
    bus.ch_mask = 16'hFFFF;
    pat         = 16'hA5C3;
    bus.start   = 1'b1;
    vld_seen    = 1'b0;
    w = 0;
    do begin
      tick();
      w++;
      bus.start = 1'b0;
      if (bus.data_valid) vld_seen = 1'b1;
    end while (w < 100 && bus.sel != 4'd5);
    chk("reach channel 5", bus.sel, 5);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("abort scan busy", bus.busy, 0);
    chk("abort scan sel held", bus.sel, 5);
    chk("abort scan data kept", bus.data_out, held);
    repeat (40) begin
      tick();
      if (bus.data_valid) vld_seen = 1'b1;
    end
    chk("abort no valid", vld_seen, 0);

    // start/mode/ch_mask changes mid-sweep must not disturb the sweep.
    run_sweep(16'hFFFF, 16'hA5C3, 16'hA5C3, 33, 1'b1, "disturbed");

    // Asynchronous reset in the middle of a sweep.
    bus.ch_mask = 16'hFFFF;
    bus.start   = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (9) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("async rst sel", bus.sel, 0);
    chk("async rst busy", bus.busy, 0);
    chk("async rst data_out", bus.data_out, 0);
    chk("async rst valid", bus.data_valid, 0);
    #5 rst_n = 1'b1;
    tick();
    run_sweep(16'hFFFF, 16'hA5C3, 16'hA5C3, 33, 1'b0, "after reset");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/mux_scan_seq.md
# mux_scan_seq

Scan sequencer for the 16:1 channel multiplexer. It drives the mux select, waits a programmable settle time per channel, and samples the mux output. It assembles one 16-bit snapshot per sweep and hands it downstream over a valid/ready handshake. Single-sweep and continuous modes are supported, and masked channels are skipped.

## Interface
- `SETTLE`, default 1: extra cycles to wait after a select change before sampling (0–15).
- `NUM_CH`, default 16: channel count. Fixed at 16; not for override.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  reset; asynchronous and active-low.
- `start`  in  1  begin a sweep; honoured only in IDLE.
- `abort`  in  1  terminate the current sweep or continuous run.
- `mode`  in  1  0 = single sweep, 1 = continuous; sampled with `start`.
- `ch_mask`  in  16  bit k = 1 enables channel k; latched at sweep start.
- `sel`  out  4  registered mux select.
- `q_in`  in  1  mux output, combinationally dependent on `sel`.
- `busy`  out  1  high in any state other than IDLE.
- `data_out`  out  16  snapshot; bit k holds the sample of channel k, and disabled channels read 0.
- `data_valid`  out  1  snapshot available; held until accepted.
- `data_ready`  in  1  downstream accept.
- `overrun`  out  1  sticky flag: in continuous mode, the next sweep was delayed because `data_ready` was low; cleared by `start` or reset.

## Operation
- States: IDLE, SCAN, OUT.
- **IDLE**
  - On `start`=1, latch `ch_mask` and `mode`, and clear the internal shift word.
  - If the mask is nonzero: load `sel` with the lowest enabled channel, clear the settle counter, and go to SCAN.
  - If the mask is all zero: go to OUT with `data_out` = 0.
- **SCAN**
  - The settle counter increments each cycle.
  - When the counter equals `SETTLE`, capture `q_in` into word bit `sel`.
  - If a higher enabled channel exists: load `sel` with it, clear the counter, and stay in SCAN.
  - Otherwise: transfer the word to `data_out`, set `data_valid`, and go to OUT.
- **OUT**
  - `data_out` and `data_valid` stay stable until `data_ready`=1 on a clock edge.
  - On that edge, clear `data_valid`.
  - In continuous mode, restart SCAN from the lowest enabled channel of the latched mask; the mask is not re-latched.
  - In single mode, return to IDLE.
- **Continuous mode with `data_ready` low in OUT:** the FSM waits and sets `overrun`. It never overwrites an unaccepted snapshot.
- **`abort`** (any state except IDLE): next state is IDLE, `data_valid` is cleared, `data_out` keeps its last value, and `sel` holds.
- **Priority:** `abort` outranks `data_ready` and sampling in the same cycle.
- **`start`** is ignored while `busy`=1. Changes to `ch_mask` mid-sweep are ignored.
- **Channel search:** strictly ascending, with no wrap inside a sweep. Channel 15 is always the last candidate.

## Timing
- **Reset values:** `sel`=0, `busy`=0, `data_out`=0, `data_valid`=0, `overrun`=0, state IDLE, counter 0. These apply immediately on `rst_n` falling, mid-sweep included; no snapshot is emitted.
- **Per-channel dwell:** SETTLE+1 cycles. `sel` changes on edge t, and `q_in` is sampled on edge t+SETTLE+1 (with SETTLE=0, the edge after the change).
- **Latency:** `start` edge → `data_valid` high takes N_en·(SETTLE+1)+1 cycles, where N_en is the enabled channel count. With an all-zero mask, `data_valid` is high 1 cycle after `start`.
- **Back-to-back continuous sweeps:** the `data_ready` acceptance edge also loads `sel` for the next sweep. There is no idle cycle.
- **`busy`:** rises on the edge after `start`; falls on the edge that enters IDLE.

## Structure
- **Shared package `mux_scan_pkg`:**
  - state enum (IDLE/SCAN/OUT)
  - `NUM_CH`=16
  - `SEL_W`=4
  - maximum `SETTLE` constant (15)
- **Sub-module `scan_next_ch`:** combinational lowest-set-bit finder over `mask & above(cur)`. It returns `found` and the 4-bit channel, and is used both for the first-channel load and for each advance.
- The FSM, settle counter, and output registers live in `mux_scan_seq`.

## Test plan
- **Full sweep:** SETTLE=1, mask 0xFFFF, mux inputs pattern 0xA5C3, single `start` → `data_valid` on cycle 33, `data_out`=0xA5C3, `sel` visits 0..15 in order.
- **Sparse mask:** mask 0x8101, same pattern → only channels 0, 8, 15 visited; `data_out`=0x8101 & 0xA5C3 = 0x8101; latency 7 cycles.
- **Empty mask:** mask 0x0000, `start` → `data_valid` 1 cycle later, `data_out`=0, `sel` unchanged.
- **Continuous backpressure:** mode=1, mask 0x000F, `data_ready` low for 10 cycles after the first valid → `data_out` stable, `overrun`=1, `sel` frozen. When `data_ready` rises, the second sweep starts on the same edge with `sel`=0.
- **Abort and reset mid-sweep:** `abort` at channel 5 → IDLE next cycle, `data_valid` never rises. `rst_n` low mid-sweep → all outputs at reset values asynchronously. A following `start` → a clean full sweep.
- **Ignored inputs while busy:** `start` pulsed during SCAN and `ch_mask` changed mid-sweep → no effect on the sequence or the result.
